exe_mem_pipe_reg: RTL and testbench

Parametrised EXE→MEM pipeline register for the five-stage core. It captures the execute-stage result, the store value, the destination register and the memory/writeback control bits each cycle. It adds a valid bit, freeze (stall) and flush (bubble) control, a forwarding tap, and load-use hazard detection for the decode stage. Two saturating performance counters track stage occupancy and inserted bubbles.

---
 rtl/exe_mem_pipe_reg_pkg.sv | 15 +
 rtl/exe_mem_pipe_reg_sat_counter.sv | 35 +++
 rtl/exe_mem_pipe_reg.sv | 118 +++++++++++
 tb/tb_exe_mem_pipe_reg.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_mem_pipe_reg_pkg.sv
// Shared core definitions: default datapath widths and the memory/writeback
// control bundle carried between the ID/EXE, EXE/MEM and MEM/WB stage registers.
package exe_mem_pipe_reg_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int PC_W_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } mem_ctrl_t;

endpackage

// File: rtl/exe_mem_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// The clear takes precedence over an increment in the same cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM stage register with stall/bubble control, a forwarding tap,
// load-use hazard detection for decode, and occupancy/bubble counters.
module exe_mem_pipe_reg
  import exe_mem_pipe_reg_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PC_W       = PC_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze_in,
  input  logic                  flush_in,
  input  logic                  cnt_clr_in,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [PC_W-1:0]       pc_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     st_val_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] hz_src1_in,
  input  logic [REG_ADDR_W-1:0] hz_src2_in,
  output logic                  valid,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic [PC_W-1:0]       pc_out,
  output logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     st_val,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  fwd_en,
  output logic                  load_use_hazard,
  output logic [CNT_W-1:0]      occ_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
);

  logic                  valid_reg;
  mem_ctrl_t             ctrl_reg;
  mem_ctrl_t             ctrl_gated;
  logic [PC_W-1:0]       pc_reg;
  logic [DATA_W-1:0]     alu_reg;
  logic [DATA_W-1:0]     st_reg;
  logic [REG_ADDR_W-1:0] dest_reg;

  // An invalid slot must never write memory or the register file downstream.
  assign ctrl_gated.wb_en    = wb_en_in    & valid_in;
  assign ctrl_gated.mem_r_en = mem_r_en_in & valid_in;
  assign ctrl_gated.mem_w_en = mem_w_en_in & valid_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      pc_reg    <= '0;
      alu_reg   <= '0;
      st_reg    <= '0;
      dest_reg  <= '0;
    end else if (flush_in) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      pc_reg    <= '0;
      alu_reg   <= '0;
      st_reg    <= '0;
      dest_reg  <= '0;
    end else if (!freeze_in) begin
      valid_reg <= valid_in;
      ctrl_reg  <= ctrl_gated;
      pc_reg    <= pc_in;
      alu_reg   <= alu_result_in;
      st_reg    <= st_val_in;
      dest_reg  <= dest_in;
    end
  end

  assign valid      = valid_reg;
  assign wb_en      = ctrl_reg.wb_en;
  assign mem_r_en   = ctrl_reg.mem_r_en;
  assign mem_w_en   = ctrl_reg.mem_w_en;
  assign pc_out     = pc_reg;
  assign alu_result = alu_reg;
  assign st_val     = st_reg;
  assign dest       = dest_reg;

  // r0 is hardwired to zero, so it is never a forwarding or hazard source.
  logic dest_nz;
  assign dest_nz = (dest_reg != '0);

  // A load's alu_result is an address, not the value decode wants.
  assign fwd_en = valid_reg & ctrl_reg.wb_en & ~ctrl_reg.mem_r_en & dest_nz;

  assign load_use_hazard = valid_reg & ctrl_reg.mem_r_en & dest_nz &
                           ((dest_reg == hz_src1_in) | (dest_reg == hz_src2_in));

  logic occ_inc;
  logic bubble_inc;
  assign occ_inc    = valid_reg & ~freeze_in;
  assign bubble_inc = flush_in | (~freeze_in & ~valid_in);

  sat_counter #(.W(CNT_W)) u_occ_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_in),
    .inc   (occ_inc),
    .count (occ_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_in),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg with 4-bit counters so saturation is
// reachable quickly; each scenario task checks its own hand-computed values.
module tb_exe_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze_in, flush_in, cnt_clr_in, valid_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] pc_in, alu_result_in, st_val_in;
  logic [4:0]  dest_in, hz_src1_in, hz_src2_in;
  logic        valid, wb_en, mem_r_en, mem_w_en;
  logic [31:0] pc_out, alu_result, st_val;
  logic [4:0]  dest;
  logic        fwd_en, load_use_hazard;
  logic [3:0]  occ_cnt, bubble_cnt;

  int checks = 0;
  int errors = 0;

  exe_mem_pipe_reg #(.DATA_W(32), .PC_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .freeze_in(freeze_in), .flush_in(flush_in),
    .cnt_clr_in(cnt_clr_in), .valid_in(valid_in), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .pc_in(pc_in),
    .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
    .hz_src1_in(hz_src1_in), .hz_src2_in(hz_src2_in), .valid(valid),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .pc_out(pc_out),
    .alu_result(alu_result), .st_val(st_val), .dest(dest), .fwd_en(fwd_en),
    .load_use_hazard(load_use_hazard), .occ_cnt(occ_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    freeze_in = 0; flush_in = 0; cnt_clr_in = 0;
    valid_in = 1; wb_en_in = 1; mem_r_en_in = 0; mem_w_en_in = 0;
    pc_in = 32'h100; alu_result_in = 32'h0000_00A5; st_val_in = 32'h55;
    dest_in = 5'd3; hz_src1_in = 5'd0; hz_src2_in = 5'd0;
    repeat (2) tick();
    checks++;
    if ({valid, wb_en, mem_r_en, mem_w_en, fwd_en, load_use_hazard} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {valid, wb_en, mem_r_en, mem_w_en, fwd_en, load_use_hazard});
    end
    checks++;
    if ({pc_out, alu_result, st_val, dest} !== '0) begin
      errors++;
      $display("FAIL reset_data got pc=%h alu=%h st=%h dest=%0d want all 0",
               pc_out, alu_result, st_val, dest);
    end
    checks++;
    if ({occ_cnt, bubble_cnt} !== 8'h00) begin
      errors++;
      $display("FAIL reset_cnt got occ=%0d bub=%0d want 0 0", occ_cnt, bubble_cnt);
    end
    $display("reset: valid=%b occ=%0d bub=%0d", valid, occ_cnt, bubble_cnt);
  endtask

  task automatic test_load();
    rst = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || alu_result !== 32'hA5 || dest !== 5'd3 || fwd_en !== 1'b1) begin
      errors++;
      $display("FAIL load got valid=%b alu=%h dest=%0d fwd=%b want 1 a5 3 1",
               valid, alu_result, dest, fwd_en);
    end
    checks++;
    if (pc_out !== 32'h100 || st_val !== 32'h55 || wb_en !== 1'b1) begin
      errors++;
      $display("FAIL load_pc got pc=%h st=%h wb=%b want 100 55 1", pc_out, st_val, wb_en);
    end
    checks++;
    if (occ_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
      errors++;
      $display("FAIL load_cnt0 got occ=%0d bub=%0d want 0 0", occ_cnt, bubble_cnt);
    end
    tick();
    checks++;
    if (occ_cnt !== 4'd1) begin
      errors++;
      $display("FAIL load_cnt1 got occ=%0d want 1", occ_cnt);
    end
    $display("load: alu=%h dest=%0d fwd=%b occ=%0d", alu_result, dest, fwd_en, occ_cnt);
  endtask

  task automatic test_freeze();
    freeze_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_result_in = 32'hDEAD_0000 + i;
      dest_in = 5'd9;
      valid_in = 1'b0;
      pc_in = 32'h200;
      tick();
      checks++;
      if (valid !== 1'b1 || alu_result !== 32'hA5 || dest !== 5'd3 || pc_out !== 32'h100) begin
        errors++;
        $display("FAIL freeze_hold[%0d] got valid=%b alu=%h dest=%0d pc=%h want 1 a5 3 100",
                 i, valid, alu_result, dest, pc_out);
      end
      checks++;
      if (occ_cnt !== 4'd1 || bubble_cnt !== 4'd0) begin
        errors++;
        $display("FAIL freeze_cnt[%0d] got occ=%0d bub=%0d want 1 0", i, occ_cnt, bubble_cnt);
      end
      $display("freeze[%0d]: alu=%h occ=%0d bub=%0d", i, alu_result, occ_cnt, bubble_cnt);
    end
  endtask

  task automatic test_flush();
    flush_in = 1'b1;
    tick();
    checks++;
    if ({valid, wb_en, mem_r_en, mem_w_en, fwd_en} !== 5'b0 ||
        {pc_out, alu_result, st_val, dest} !== '0) begin
      errors++;
      $display("FAIL flush_fields got valid=%b wb=%b pc=%h alu=%h st=%h dest=%0d want all 0",
               valid, wb_en, pc_out, alu_result, st_val, dest);
    end
    checks++;
    if (occ_cnt !== 4'd1 || bubble_cnt !== 4'd1) begin
      errors++;
      $display("FAIL flush_cnt got occ=%0d bub=%0d want 1 1", occ_cnt, bubble_cnt);
    end
    $display("flush: valid=%b occ=%0d bub=%0d", valid, occ_cnt, bubble_cnt);
    flush_in = 1'b0;
    freeze_in = 1'b0;
  endtask

  task automatic test_load_use();
    valid_in = 1; wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 0;
    dest_in = 5'd7; hz_src1_in = 5'd1; hz_src2_in = 5'd7; alu_result_in = 32'h1000;
    tick();
    checks++;
    if (load_use_hazard !== 1'b1 || fwd_en !== 1'b0 || mem_r_en !== 1'b1) begin
      errors++;
      $display("FAIL lu_hit got hz=%b fwd=%b mr=%b want 1 0 1", load_use_hazard, fwd_en, mem_r_en);
    end
    hz_src2_in = 5'd8;
    #1;
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++;
      $display("FAIL lu_miss got hz=%b want 0", load_use_hazard);
    end
    hz_src1_in = 5'd7;
    #1;
    checks++;
    if (load_use_hazard !== 1'b1) begin
      errors++;
      $display("FAIL lu_src1 got hz=%b want 1", load_use_hazard);
    end
    dest_in = 5'd0; hz_src1_in = 5'd0; hz_src2_in = 5'd0;
    tick();
    checks++;
    if (load_use_hazard !== 1'b0) begin
      errors++;
      $display("FAIL lu_r0 got hz=%b want 0", load_use_hazard);
    end
    mem_r_en_in = 0;
    tick();
    checks++;
    if (fwd_en !== 1'b0 || wb_en !== 1'b1) begin
      errors++;
      $display("FAIL fwd_r0 got fwd=%b wb=%b want 0 1", fwd_en, wb_en);
    end
    $display("load_use: hz=%b fwd=%b dest=%0d", load_use_hazard, fwd_en, dest);
  endtask

  task automatic test_invalid();
    cnt_clr_in = 1; valid_in = 1; wb_en_in = 1; mem_r_en_in = 0; dest_in = 5'd4;
    tick();
    checks++;
    if (occ_cnt !== 4'd0 || bubble_cnt !== 4'd0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL clr got occ=%0d bub=%0d valid=%b want 0 0 1", occ_cnt, bubble_cnt, valid);
    end
    cnt_clr_in = 0; valid_in = 0; mem_w_en_in = 1; wb_en_in = 1; alu_result_in = 32'h77;
    tick();
    checks++;
    if (valid !== 1'b0 || mem_w_en !== 1'b0 || wb_en !== 1'b0 || alu_result !== 32'h77) begin
      errors++;
      $display("FAIL invalid_gate got valid=%b mw=%b wb=%b alu=%h want 0 0 0 77",
               valid, mem_w_en, wb_en, alu_result);
    end
    checks++;
    if (occ_cnt !== 4'd1 || bubble_cnt !== 4'd1) begin
      errors++;
      $display("FAIL invalid_cnt got occ=%0d bub=%0d want 1 1", occ_cnt, bubble_cnt);
    end
    $display("invalid: mw=%b valid=%b bub=%0d", mem_w_en, valid, bubble_cnt);
    mem_w_en_in = 0;
  endtask

  task automatic test_saturation();
    cnt_clr_in = 1; valid_in = 1;
    tick();
    cnt_clr_in = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (occ_cnt !== ((k < 15) ? 4'(k) : 4'd15)) begin
        errors++;
        $display("FAIL sat_occ[%0d] got %0d want %0d", k, occ_cnt, (k < 15) ? k : 15);
      end
    end
    checks++;
    if (bubble_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_bub got %0d want 0", bubble_cnt);
    end
    $display("saturate: occ=%0d", occ_cnt);
    cnt_clr_in = 1;
    tick();
    cnt_clr_in = 0;
    checks++;
    if (occ_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_clr got %0d want 0", occ_cnt);
    end
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || alu_result !== 32'h0 || dest !== 5'd0 || occ_cnt !== 4'd0 || wb_en !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got valid=%b alu=%h dest=%0d occ=%0d wb=%b want 0 0 0 0 0",
               valid, alu_result, dest, occ_cnt, wb_en);
    end
    $display("async_rst: valid=%b occ=%0d", valid, occ_cnt);
    #1 rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] alu_tab [3];
    logic [4:0]  dest_tab [3];
    alu_tab[0] = 32'h11; alu_tab[1] = 32'h22; alu_tab[2] = 32'h33;
    dest_tab[0] = 5'd1;  dest_tab[1] = 5'd2;  dest_tab[2] = 5'd30;
    valid_in = 1; wb_en_in = 1; mem_r_en_in = 0; mem_w_en_in = 0;
    for (int i = 0; i < 3; i++) begin
      alu_result_in = alu_tab[i];
      dest_in = dest_tab[i];
      pc_in = 32'h400 + 32'(4 * i);
      tick();
      checks++;
      if (alu_result !== alu_tab[i] || dest !== dest_tab[i] || pc_out !== 32'h400 + 32'(4 * i)) begin
        errors++;
        $display("FAIL b2b[%0d] got alu=%h dest=%0d pc=%h want %h %0d %h",
                 i, alu_result, dest, pc_out, alu_tab[i], dest_tab[i], 32'h400 + 32'(4 * i));
      end
      $display("b2b[%0d]: alu=%h dest=%0d", i, alu_result, dest);
    end
    freeze_in = 1;
    tick();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0 || alu_result !== 32'h0) begin
      errors++;
      $display("FAIL rst_freeze got valid=%b alu=%h want 0 0", valid, alu_result);
    end
    $display("rst_mid_freeze: valid=%b", valid);
    freeze_in = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_freeze();
    test_flush();
    test_load_use();
    test_invalid();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
